pass_sequencer: RTL and testbench
=================================

// Module: pass_sequencer
// PURPOSE
//  Per-pass step engine under the training controller: consumes f0/f1/b pass levels, walks the weight index space,
//  issues MAC (forward) / update (backward) enables, and returns f_end / b_end / zero_end_check to the controller.
//  Also accumulates |error| during forward passes for the convergence check; zero_loss_i clears it.
// PARAMETERS
//  N_W          4   number of weights stepped per pass (>=1)
//  AW           2   weight address width (2**AW >= N_W)
//  LW           8   signed error sample width
//  MAC_LAT      2   datapath drain cycles after last step (>=0)
//  LOSS_THRESH  0   converged when accumulated loss <= this value
//  MAX_ITER     15  backward-pass limit (only with PASS_SEQ_ITER_LIMIT_EN)
// PORTS
//  clk_i             in   1       clock
//  rst_i             in   1       async active-low reset
//  en_i              in   1       global enable; low freezes every register
//  f0_pass_i         in   1       controller: first forward pass active
//  f1_pass_i         in   1       controller: subsequent forward pass active
//  b_pass_i          in   1       controller: backward pass active
//  zero_loss_i       in   1       clear loss accumulator (sync, honoured only when en_i)
//  loss_vld_i        in   1       error sample valid
//  loss_i            in   LW      signed error sample
//  w_addr_o          out  AW      current weight index
//  mac_en_o          out  1       forward step strobe
//  upd_en_o          out  1       backward update strobe
//  f_end_o           out  1       1-cycle pulse: forward pass done, not converged
//  b_end_o           out  1       1-cycle pulse: backward pass done
//  zero_end_check_o  out  1       1-cycle pulse: f1 pass done and converged
//  loss_acc_o        out  LW+4    loss accumulator (unsigned, saturating)
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, loss_acc_o 0, iteration count 0. All outputs registered.
//  - en_i=0: no state/counter/accumulator change; strobes and pulses hold their value.
//  - Pass select when >1 input high: b > f1 > f0. Selected kind latched on IDLE->RUN.
//  - IDLE: any pass high -> RUN, idx=0.
//  - RUN: w_addr_o=idx; mac_en_o=1 (f0/f1) or upd_en_o=1 (b), one step per enabled cycle.
//    idx==N_W-1 -> DRAIN (MAC_LAT=0: straight to END). N_W steps exactly, no wrap.
//  - DRAIN: strobes 0, count MAC_LAT enabled cycles -> END.
//  - END (one cycle): b -> b_end_o; f0 -> f_end_o; f1 -> zero_end_check_o if loss_acc_o<=LOSS_THRESH, else f_end_o.
//    Never both f_end_o and zero_end_check_o. -> DONE.
//  - DONE: wait until latched pass input low -> IDLE (no repeated end pulse if controller stalls).
//  - Latched pass input drops in RUN/DRAIN (abort) -> IDLE next cycle, no end pulse, strobes 0.
//  - Loss: in RUN/DRAIN of a forward pass, loss_vld_i adds |loss_i| (-2**(LW-1) -> 2**(LW-1)),
//    saturates at all-ones. zero_loss_i has priority over a same-cycle add (result 0).
//  - Reset mid-pass: immediate return to reset values; restart needs a new pass level.
// CONFIGURATION
//  PASS_SEQ_ITER_LIMIT_EN defined: count of b_end_o pulses (saturating); once >= MAX_ITER, next f1 END
//    emits zero_end_check_o regardless of loss. Undefined: no counter; convergence by loss only.
// TESTING
//  1 reset: rst_i=0 mid-RUN -> all outputs 0 same cycle, loss_acc_o=0, IDLE after release.
//  2 f0_pass_i=1, N_W=4, MAC_LAT=2 -> mac_en_o 4 cycles, w_addr_o 0,1,2,3, 2 idle cycles, then f_end_o 1 cycle.
//  3 b_pass_i=1 -> upd_en_o 4 cycles, b_end_o 1 cycle; pass held 5 more cycles -> no second pulse.
//  4 f1 pass, losses +3,-5 (acc 8), THRESH=0 -> f_end_o; after zero_loss_i, f1 with losses 0 -> zero_end_check_o only.
//  5 en_i=0 for 3 cycles at idx=2 -> w_addr_o stays 2, total strobes still 4; loss_i=-128 x20 -> acc 2560 then saturates 4095.
//  6 PASS_SEQ_ITER_LIMIT_EN, MAX_ITER=2: two b passes, loss high -> next f1 END gives zero_end_check_o.

Source files
------------

// File: rtl/pass_sequencer.sv
// Per-pass step engine: walks N_W weight indices for forward (MAC) or backward (update) passes,
// accumulates |error| for the convergence check. Optional macro: PASS_SEQ_ITER_LIMIT_EN (backward-pass limit).
module pass_sequencer #(
   parameter int N_W         = 4,
   parameter int AW          = 2,
   parameter int LW          = 8,
   parameter int MAC_LAT     = 2,
   parameter int LOSS_THRESH = 0,
   parameter int MAX_ITER    = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 f0_pass_i,
   input  logic                 f1_pass_i,
   input  logic                 b_pass_i,
   input  logic                 zero_loss_i,
   input  logic                 loss_vld_i,
   input  logic signed [LW-1:0] loss_i,
   output logic [AW-1:0]        w_addr_o,
   output logic                 mac_en_o,
   output logic                 upd_en_o,
   output logic                 f_end_o,
   output logic                 b_end_o,
   output logic                 zero_end_check_o,
   output logic [LW+3:0]        loss_acc_o
);

   localparam int ACC_W = LW + 4;
   localparam int DW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_END, S_DONE} state_t;
   typedef enum logic [1:0] {K_F0, K_F1, K_B} kind_t;

   state_t             state_reg, state_next;
   kind_t              kind_reg, kind_next, sel_kind;
   logic [AW-1:0]      idx_reg, idx_next;
   logic [DW-1:0]      drain_reg, drain_next;
   logic               mac_reg, mac_next;
   logic               upd_reg, upd_next;
   logic               f_end_reg, f_end_next;
   logic               b_end_reg, b_end_next;
   logic               zec_reg, zec_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;

   logic               pass_any, pass_lvl;
   logic [LW-1:0]      loss_neg;
   logic [LW:0]        abs_loss;
   logic [ACC_W:0]     acc_sum;
   logic               converged, iter_hit;
   logic               end_f, end_b, end_z;

   assign pass_any = f0_pass_i | f1_pass_i | b_pass_i;
   assign sel_kind = b_pass_i ? K_B : (f1_pass_i ? K_F1 : K_F0);

   always_comb begin
      pass_lvl = 1'b0;
      case (kind_reg)
         K_F0:    pass_lvl = f0_pass_i;
         K_F1:    pass_lvl = f1_pass_i;
         K_B:     pass_lvl = b_pass_i;
         default: pass_lvl = 1'b0;
      endcase
   end

   // |loss| needs LW+1 bits so that the most negative sample maps to +2**(LW-1)
   assign loss_neg = ~loss_i + LW'(1);
   assign abs_loss = loss_i[LW-1] ? {1'b0, loss_neg} : {1'b0, loss_i};
   assign acc_sum  = {1'b0, acc_reg} + (ACC_W+1)'(abs_loss);

   always_comb begin
      acc_next = acc_reg;
      if (zero_loss_i)
         acc_next = '0;
      else if ((state_reg == S_RUN || state_reg == S_DRAIN) && kind_reg != K_B && loss_vld_i)
         acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
   end

   // Decision uses the value loss_acc_o will show during END, including a last-cycle sample
   assign converged = (acc_next <= ACC_W'(LOSS_THRESH)) | iter_hit;
   assign end_b     = (kind_reg == K_B);
   assign end_z     = (kind_reg == K_F1) & converged;
   assign end_f     = (kind_reg == K_F0) | ((kind_reg == K_F1) & ~converged);

`ifdef PASS_SEQ_ITER_LIMIT_EN
   localparam int IW = $clog2(MAX_ITER + 2);
   logic [IW-1:0] iter_reg;

   assign iter_hit = (iter_reg >= IW'(MAX_ITER));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         iter_reg <= '0;
      else if (en_i && b_end_next && !iter_hit)
         iter_reg <= iter_reg + IW'(1);
   end
`else
   // No iteration limit in this build; convergence is decided by loss only
   assign iter_hit = (MAX_ITER < 0);
`endif

   always_comb begin
      state_next = state_reg;
      kind_next  = kind_reg;
      idx_next   = idx_reg;
      drain_next = drain_reg;
      mac_next   = 1'b0;
      upd_next   = 1'b0;
      f_end_next = 1'b0;
      b_end_next = 1'b0;
      zec_next   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (pass_any) begin
               state_next = S_RUN;
               kind_next  = sel_kind;
               idx_next   = '0;
               mac_next   = (sel_kind != K_B);
               upd_next   = (sel_kind == K_B);
            end
         end
         S_RUN: begin
            if (!pass_lvl) begin
               state_next = S_IDLE;
            end else if (idx_reg == AW'(N_W - 1)) begin
               drain_next = '0;
               if (MAC_LAT == 0) begin
                  state_next = S_END;
                  f_end_next = end_f;
                  b_end_next = end_b;
                  zec_next   = end_z;
               end else begin
                  state_next = S_DRAIN;
               end
            end else begin
               idx_next = idx_reg + AW'(1);
               mac_next = (kind_reg != K_B);
               upd_next = (kind_reg == K_B);
            end
         end
         S_DRAIN: begin
            if (!pass_lvl) begin
               state_next = S_IDLE;
            end else if (drain_reg == DW'(MAC_LAT - 1)) begin
               state_next = S_END;
               f_end_next = end_f;
               b_end_next = end_b;
               zec_next   = end_z;
            end else begin
               drain_next = drain_reg + DW'(1);
            end
         end
         S_END:   state_next = S_DONE;
         S_DONE:  if (!pass_lvl) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= S_IDLE;
         kind_reg  <= K_F0;
         idx_reg   <= '0;
         drain_reg <= '0;
         mac_reg   <= 1'b0;
         upd_reg   <= 1'b0;
         f_end_reg <= 1'b0;
         b_end_reg <= 1'b0;
         zec_reg   <= 1'b0;
         acc_reg   <= '0;
      end else if (en_i) begin
         state_reg <= state_next;
         kind_reg  <= kind_next;
         idx_reg   <= idx_next;
         drain_reg <= drain_next;
         mac_reg   <= mac_next;
         upd_reg   <= upd_next;
         f_end_reg <= f_end_next;
         b_end_reg <= b_end_next;
         zec_reg   <= zec_next;
         acc_reg   <= acc_next;
      end
   end

   assign w_addr_o         = idx_reg;
   assign mac_en_o         = mac_reg;
   assign upd_en_o         = upd_reg;
   assign f_end_o          = f_end_reg;
   assign b_end_o          = b_end_reg;
   assign zero_end_check_o = zec_reg;
   assign loss_acc_o       = acc_reg;

endmodule

// File: tb/tb_pass_sequencer.sv
// Testbench for pass_sequencer: table of pass records plus hand-written freeze/abort/reset/iteration sequences.
module tb_pass_sequencer;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              en_i;
   logic              f0_pass_i, f1_pass_i, b_pass_i;
   logic              zero_loss_i, loss_vld_i;
   logic signed [7:0] loss_i;
   logic [1:0]        w_addr_o;
   logic              mac_en_o, upd_en_o, f_end_o, b_end_o, zero_end_check_o;
   logic [11:0]       loss_acc_o;

   pass_sequencer #(
      .N_W(4), .AW(2), .LW(8), .MAC_LAT(2), .LOSS_THRESH(0), .MAX_ITER(2)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
      .f0_pass_i(f0_pass_i), .f1_pass_i(f1_pass_i), .b_pass_i(b_pass_i),
      .zero_loss_i(zero_loss_i), .loss_vld_i(loss_vld_i), .loss_i(loss_i),
      .w_addr_o(w_addr_o), .mac_en_o(mac_en_o), .upd_en_o(upd_en_o),
      .f_end_o(f_end_o), .b_end_o(b_end_o), .zero_end_check_o(zero_end_check_o),
      .loss_acc_o(loss_acc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0] addr;
      logic       mac;
      logic       upd;
      logic       fe;
      logic       be;
      logic       zc;
      logic [11:0] acc;
   } obs_t;

   // kind: 0=f0, 1=f1, 2=b, 3=all three high; exp_end = {f_end, b_end, zero_end_check}
   typedef struct packed {
      logic [1:0]      kind;
      logic            clr;
      logic [5:0]      vld;
      logic [5:0][7:0] l;
      logic [2:0]      exp_end;
   } vec_t;

   obs_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   macc  = 0;
   logic [1:0] maddr = 2'd0;
   int   mac_seen;
   vec_t tbl[12];

   function automatic obs_t mk(input logic [1:0] a, input logic m, input logic u, input logic [2:0] p);
      obs_t o;
      o = {a, m, u, p, 12'(macc)};
      return o;
   endfunction

   function automatic vec_t mkv(input logic [1:0] kind, input logic clr, input logic [5:0] vld,
                                input logic [7:0] l0, input logic [7:0] l1, input logic [2:0] e);
      vec_t v;
      v.kind = kind; v.clr = clr; v.vld = vld; v.exp_end = e;
      v.l[0] = l0;
      for (int i = 1; i < 6; i++) v.l[i] = l1;
      return v;
   endfunction

   task automatic check_now(input string name);
      obs_t exp_o, act_o;
      exp_o = sb_q.pop_front();
      act_o = {w_addr_o, mac_en_o, upd_en_o, f_end_o, b_end_o, zero_end_check_o, loss_acc_o};
      tests++;
      if (act_o !== exp_o) begin
         fails++;
         $display("FAIL %s: got addr=%0d mac=%b upd=%b fe=%b be=%b zc=%b acc=%0d, expected addr=%0d mac=%b upd=%b fe=%b be=%b zc=%b acc=%0d",
                  name, act_o.addr, act_o.mac, act_o.upd, act_o.fe, act_o.be, act_o.zc, act_o.acc,
                  exp_o.addr, exp_o.mac, exp_o.upd, exp_o.fe, exp_o.be, exp_o.zc, exp_o.acc);
      end
   endtask

   task automatic expect_cycle(input string name, input obs_t e);
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_now(name);
   endtask

   task automatic set_pass(input logic [1:0] kind, input logic on);
      f0_pass_i = on && (kind == 2'd0 || kind == 2'd3);
      f1_pass_i = on && (kind == 2'd1 || kind == 2'd3);
      b_pass_i  = on && (kind == 2'd2 || kind == 2'd3);
   endtask

   task automatic run_pass(input vec_t v, input int row);
      logic fwd;
      logic [2:0] p;
      int s;
      fwd = (v.kind < 2'd2);
      if (v.clr) begin
         zero_loss_i = 1'b1;
         macc = 0;
         expect_cycle("clear", mk(maddr, 1'b0, 1'b0, 3'b000));
         zero_loss_i = 1'b0;
      end
      set_pass(v.kind, 1'b1);
      for (int k = 0; k < 12; k++) begin
         if (k >= 1 && k <= 6 && fwd && v.vld[k-1]) begin
            s = $signed(v.l[k-1]);
            macc = macc + ((s < 0) ? -s : s);
            if (macc > 4095) macc = 4095;
         end
         p = (k == 6) ? v.exp_end : 3'b000;
         if (k < 4) begin
            maddr = 2'(k);
            expect_cycle($sformatf("row%0d step%0d", row, k), mk(maddr, fwd, !fwd, p));
         end else begin
            expect_cycle($sformatf("row%0d cyc%0d", row, k), mk(maddr, 1'b0, 1'b0, p));
         end
         loss_vld_i = (k < 6) ? v.vld[k] : 1'b0;
         loss_i     = (k < 6) ? $signed(v.l[k]) : 8'sd0;
      end
      set_pass(v.kind, 1'b0);
      loss_vld_i = 1'b0;
      expect_cycle($sformatf("row%0d release", row), mk(maddr, 1'b0, 1'b0, 3'b000));
      expect_cycle($sformatf("row%0d idle", row), mk(maddr, 1'b0, 1'b0, 3'b000));
      $display("[TB] row %0d kind=%0d end=%b acc=%0d", row, v.kind, v.exp_end, macc);
   endtask

   initial begin
      tbl[0]  = mkv(2'd0, 1'b0, 6'b000000, 8'h00, 8'h00, 3'b100);
      tbl[1]  = mkv(2'd1, 1'b0, 6'b000011, 8'h03, 8'hFB, 3'b100);
      tbl[2]  = mkv(2'd1, 1'b1, 6'b111111, 8'h00, 8'h00, 3'b001);
      tbl[3]  = mkv(2'd1, 1'b0, 6'b000001, 8'h7F, 8'h00, 3'b100);
      tbl[4]  = mkv(2'd0, 1'b1, 6'b111111, 8'h80, 8'h80, 3'b100);
      tbl[5]  = mkv(2'd0, 1'b0, 6'b111111, 8'h80, 8'h80, 3'b100);
      tbl[6]  = mkv(2'd0, 1'b0, 6'b111111, 8'h80, 8'h80, 3'b100);
      tbl[7]  = mkv(2'd0, 1'b0, 6'b111111, 8'h80, 8'h80, 3'b100);
      tbl[8]  = mkv(2'd0, 1'b0, 6'b111111, 8'h80, 8'h80, 3'b100);
      tbl[9]  = mkv(2'd1, 1'b0, 6'b111111, 8'h80, 8'h80, 3'b100);
      tbl[10] = mkv(2'd2, 1'b0, 6'b111111, 8'hFF, 8'hFF, 3'b010);
      tbl[11] = mkv(2'd3, 1'b0, 6'b111111, 8'h01, 8'h01, 3'b010);

      rst_i = 1'b0; en_i = 1'b1;
      f0_pass_i = 1'b0; f1_pass_i = 1'b0; b_pass_i = 1'b0;
      zero_loss_i = 1'b0; loss_vld_i = 1'b0; loss_i = 8'sd0;
      repeat (2) @(posedge clk_i);
      #1;
      sb_q.push_back(mk(2'd0, 1'b0, 1'b0, 3'b000));
      check_now("reset state");
      @(negedge clk_i) rst_i = 1'b1;
      @(posedge clk_i); #1;

      for (int r = 0; r < 12; r++) run_pass(tbl[r], r);

      // en_i low for 3 cycles at idx 2; a zero_loss_i request while disabled is ignored
      mac_seen = 0;
      f0_pass_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         maddr = 2'(k);
         expect_cycle($sformatf("freeze step%0d", k), mk(maddr, 1'b1, 1'b0, 3'b000));
         mac_seen += int'(mac_en_o);
      end
      en_i = 1'b0; zero_loss_i = 1'b1;
      for (int k = 0; k < 3; k++)
         expect_cycle($sformatf("frozen%0d", k), mk(2'd2, 1'b1, 1'b0, 3'b000));
      en_i = 1'b1; zero_loss_i = 1'b0;
      maddr = 2'd3;
      expect_cycle("freeze step3", mk(maddr, 1'b1, 1'b0, 3'b000));
      mac_seen += int'(mac_en_o);
      for (int k = 4; k < 8; k++) begin
         expect_cycle($sformatf("freeze cyc%0d", k), mk(maddr, 1'b0, 1'b0, (k == 6) ? 3'b100 : 3'b000));
         mac_seen += int'(mac_en_o);
      end
      tests++;
      if (mac_seen != 4) begin
         fails++;
         $display("FAIL freeze strobe count: got %0d expected 4", mac_seen);
      end
      f0_pass_i = 1'b0;
      expect_cycle("freeze release", mk(maddr, 1'b0, 1'b0, 3'b000));
      $display("[TB] freeze sequence strobes=%0d", mac_seen);

      // Abort: pass level dropped mid-RUN returns to IDLE with no end pulse
      f0_pass_i = 1'b1;
      maddr = 2'd0; expect_cycle("abort step0", mk(maddr, 1'b1, 1'b0, 3'b000));
      maddr = 2'd1; expect_cycle("abort step1", mk(maddr, 1'b1, 1'b0, 3'b000));
      f0_pass_i = 1'b0;
      for (int k = 0; k < 8; k++)
         expect_cycle($sformatf("abort quiet%0d", k), mk(maddr, 1'b0, 1'b0, 3'b000));
      $display("[TB] abort sequence done");

      // Asynchronous reset mid-RUN clears everything without a clock edge
      f0_pass_i = 1'b1;
      maddr = 2'd0; expect_cycle("rst step0", mk(maddr, 1'b1, 1'b0, 3'b000));
      maddr = 2'd1; expect_cycle("rst step1", mk(maddr, 1'b1, 1'b0, 3'b000));
      rst_i = 1'b0;
      #1;
      macc = 0; maddr = 2'd0;
      sb_q.push_back(mk(maddr, 1'b0, 1'b0, 3'b000));
      check_now("async reset");
      f0_pass_i = 1'b0;
      @(negedge clk_i) rst_i = 1'b1;
      expect_cycle("post reset0", mk(maddr, 1'b0, 1'b0, 3'b000));
      expect_cycle("post reset1", mk(maddr, 1'b0, 1'b0, 3'b000));
      $display("[TB] reset sequence done");

      // Two backward passes with high loss, then an f1 pass
      run_pass(mkv(2'd0, 1'b0, 6'b000001, 8'd100, 8'h00, 3'b100), 12);
      run_pass(mkv(2'd2, 1'b0, 6'b000000, 8'h00, 8'h00, 3'b010), 13);
      run_pass(mkv(2'd2, 1'b0, 6'b000000, 8'h00, 8'h00, 3'b010), 14);
`ifdef PASS_SEQ_ITER_LIMIT_EN
      run_pass(mkv(2'd1, 1'b0, 6'b000000, 8'h00, 8'h00, 3'b001), 15);
`else
      run_pass(mkv(2'd1, 1'b0, 6'b000000, 8'h00, 8'h00, 3'b100), 15);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
